// File: rtl/flow_arbiter_fsm_if.sv
// ---------------------------------------------------------------------------
// flow_arbiter_fsm_if
// Bundles the flow-control arbiter's handshake and bus signals.
//   master : arbiter side (drives VC pops, Main FIFO push, thresholds, status)
//   slave  : surrounding FIFOs / environment side
// Signals:
//   init, umbral_lleno_in, umbral_vacio_in : threshold load request and values
//   vc_empty, vc_data, vc_rd               : virtual-channel FIFO side
//   main_full, main_almost_full            : Main FIFO status
//   main_wr, main_data                     : Main FIFO push
//   umbral_lleno, umbral_vacio             : distributed thresholds
//   grant, state, idle_out, active_out, error_out : status
// ---------------------------------------------------------------------------
interface flow_arbiter_fsm_if #(
  parameter int DATA_W   = 6,
  parameter int NUM_VC   = 4,
  parameter int UMBRAL_W = 3
);
  logic                       init;
  logic [UMBRAL_W-1:0]        umbral_lleno_in;
  logic [UMBRAL_W-1:0]        umbral_vacio_in;
  logic [NUM_VC-1:0]          vc_empty;
  logic [NUM_VC*DATA_W-1:0]   vc_data;
  logic [NUM_VC-1:0]          vc_rd;
  logic                       main_full;
  logic                       main_almost_full;
  logic                       main_wr;
  logic [DATA_W-1:0]          main_data;
  logic [UMBRAL_W-1:0]        umbral_lleno;
  logic [UMBRAL_W-1:0]        umbral_vacio;
  logic [1:0]                 grant;
  logic [2:0]                 state;
  logic                       idle_out;
  logic                       active_out;
  logic                       error_out;

  modport master (
    input  init, umbral_lleno_in, umbral_vacio_in, vc_empty, vc_data,
           main_full, main_almost_full,
    output vc_rd, main_wr, main_data, umbral_lleno, umbral_vacio, grant,
           state, idle_out, active_out, error_out
  );

  modport slave (
    output init, umbral_lleno_in, umbral_vacio_in, vc_empty, vc_data,
           main_full, main_almost_full,
    input  vc_rd, main_wr, main_data, umbral_lleno, umbral_vacio, grant,
           state, idle_out, active_out, error_out
  );
endinterface

// File: rtl/flow_arbiter_fsm.sv
// ---------------------------------------------------------------------------
// flow_arbiter_fsm
// Round-robin arbiter moving words from four virtual-channel FIFOs into the
// Main FIFO, with RESET/INIT/IDLE/ACTIVE/ERROR sequencing and threshold
// distribution.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : flow_arbiter_fsm_if.master (see interface for signal list)
// ---------------------------------------------------------------------------
module flow_arbiter_fsm #(
  parameter int DATA_W   = 6,
  parameter int NUM_VC   = 4,
  parameter int UMBRAL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  flow_arbiter_fsm_if.master   bus
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  state_e              state_q;
  logic [1:0]          grant_q;
  logic                main_wr_q;
  logic [DATA_W-1:0]   main_data_q;
  logic [UMBRAL_W-1:0] lleno_q;
  logic [UMBRAL_W-1:0] vacio_q;

  logic                any_req_s;
  logic                overflow_s;
  logic                grant_ok_s;
  logic [1:0]          winner_s;
  logic [NUM_VC-1:0]   vc_rd_s;
  logic [DATA_W-1:0]   head_s;

  // First requester after 'last' in circular order; 'last' itself is checked
  // last. Scanning from the farthest offset down lets the nearest one win.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        rr_pick = idx;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  // Grant decision and combinational pop strobe
  always_comb begin
    any_req_s  = |(~bus.vc_empty);
    // A push into a full Main FIFO is an overflow in any state but RESET.
    overflow_s = (state_q != ST_RESET) && main_wr_q && bus.main_full;
    winner_s   = rr_pick(~bus.vc_empty, grant_q);
    head_s     = bus.vc_data[winner_s*DATA_W +: DATA_W];
    // No pop on an overflow cycle: the word would be lost once ERROR is entered.
    grant_ok_s = (state_q == ST_ACTIVE) && !bus.init && !bus.main_almost_full
                 && any_req_s && !overflow_s;
    vc_rd_s    = '0;
    if (grant_ok_s) begin
      vc_rd_s[winner_s] = 1'b1;
    end else begin
      vc_rd_s = '0;
    end
  end

  // State machine, push path and threshold registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RESET;
      grant_q     <= 2'd3;
      main_wr_q   <= 1'b0;
      main_data_q <= '0;
      lleno_q     <= '0;
      vacio_q     <= '0;
    end else begin
      main_wr_q <= grant_ok_s;
      if (grant_ok_s) begin
        grant_q     <= winner_s;
        main_data_q <= head_s;
      end
      case (state_q)
        ST_RESET: state_q <= ST_INIT;
        ST_INIT: begin
          lleno_q <= bus.umbral_lleno_in;
          vacio_q <= bus.umbral_vacio_in;
          if (overflow_s)                                        state_q <= ST_ERROR;
          else if (bus.init)                                     state_q <= ST_INIT;
          else if (bus.umbral_vacio_in >= bus.umbral_lleno_in)   state_q <= ST_ERROR;
          else                                                   state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (overflow_s)     state_q <= ST_ERROR;
          else if (bus.init)  state_q <= ST_INIT;
          else if (any_req_s) state_q <= ST_ACTIVE;
          else                state_q <= ST_IDLE;
        end
        ST_ACTIVE: begin
          if (overflow_s)      state_q <= ST_ERROR;
          else if (bus.init)   state_q <= ST_INIT;
          else if (grant_ok_s) state_q <= ST_ACTIVE;
          else if (!any_req_s) state_q <= ST_IDLE;
          else                 state_q <= ST_ACTIVE;  // stalled on almost-full
        end
        ST_ERROR: state_q <= ST_ERROR;
        default:  state_q <= ST_ERROR;
      endcase
    end
  end

  assign bus.vc_rd        = vc_rd_s;
  assign bus.main_wr      = main_wr_q;
  assign bus.main_data    = main_data_q;
  assign bus.umbral_lleno = lleno_q;
  assign bus.umbral_vacio = vacio_q;
  assign bus.grant        = grant_q;
  assign bus.state        = state_q;
  assign bus.idle_out     = (state_q == ST_IDLE);
  assign bus.active_out   = (state_q == ST_ACTIVE);
  assign bus.error_out    = (state_q == ST_ERROR);

endmodule

// File: tb/tb_flow_arbiter_fsm.sv
// Self-checking bench for flow_arbiter_fsm: directed scenarios plus a
// randomized run against a behavioural model of the arbitration rules.
module tb_flow_arbiter_fsm;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flow_arbiter_fsm_if #(.DATA_W(6), .NUM_VC(4), .UMBRAL_W(3)) bus ();
  flow_arbiter_fsm #(.DATA_W(6), .NUM_VC(4), .UMBRAL_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural reference model ----------------
  int m_state, m_grant, m_wr, m_data, m_ul, m_uv;

  task automatic m_reset();
    m_state = 0; m_grant = 3; m_wr = 0; m_data = 0; m_ul = 0; m_uv = 0;
  endtask

  // VC popped this cycle, or -1 when nothing is popped
  function automatic int m_winner();
    if (m_state != 3 || bus.init || bus.main_almost_full || (m_wr != 0 && bus.main_full))
      return -1;
    for (int k = 1; k <= 4; k++) begin
      int v;
      v = (m_grant + k) % 4;
      if (!bus.vc_empty[v]) return v;
    end
    return -1;
  endfunction

  function automatic void m_step();
    int w, ns;
    bit ovf, anyv;
    w    = m_winner();
    ovf  = (m_state != 0) && (m_wr != 0) && bus.main_full;
    anyv = (bus.vc_empty != 4'hF);
    ns   = m_state;
    case (m_state)
      0: ns = 1;
      1: begin
        m_ul = bus.umbral_lleno_in;
        m_uv = bus.umbral_vacio_in;
        if (ovf) ns = 4;
        else if (!bus.init) ns = (m_uv >= m_ul) ? 4 : 2;
      end
      2: if (ovf) ns = 4; else if (bus.init) ns = 1; else if (anyv) ns = 3;
      3: if (ovf) ns = 4; else if (bus.init) ns = 1; else if (w < 0 && !anyv) ns = 2;
      default: ns = m_state;
    endcase
    m_wr = (w >= 0) ? 1 : 0;
    if (w >= 0) begin
      m_grant = w;
      m_data  = bus.vc_data[w*6 +: 6];
    end
    m_state = ns;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    m_reset();
    step();
    reset = 1'b0;
  endtask

  task automatic go_idle(input logic [2:0] ul, input logic [2:0] uv);
    bus.vc_empty = 4'hF; bus.main_full = 1'b0; bus.main_almost_full = 1'b0;
    bus.umbral_lleno_in = ul; bus.umbral_vacio_in = uv;
    bus.init = 1'b1;
    pulse_reset();
    step();             // RESET -> INIT
    step();             // stay in INIT
    bus.init = 1'b0;
    step();             // INIT -> IDLE
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.init = 1'b0; bus.vc_empty = 4'h0; bus.vc_data = 24'hABCDEF;
    bus.main_full = 1'b0; bus.main_almost_full = 1'b0;
    bus.umbral_lleno_in = 3'd5; bus.umbral_vacio_in = 3'd1;
    step();
    @(negedge clk);
    checks++;
    if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
    checks++;
    if ({bus.vc_rd, bus.main_wr, bus.main_data, bus.umbral_lleno, bus.umbral_vacio} !== 17'd0) begin
      errors++; $display("FAIL reset_outputs got rd=%b wr=%b d=%h ul=%0d uv=%0d want all 0",
                         bus.vc_rd, bus.main_wr, bus.main_data, bus.umbral_lleno, bus.umbral_vacio);
    end
    checks++;
    if (bus.grant !== 2'd3) begin errors++; $display("FAIL reset_grant got %0d want 3", bus.grant); end
    checks++;
    if ({bus.idle_out, bus.active_out, bus.error_out} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {bus.idle_out, bus.active_out, bus.error_out});
    end
    step();
  endtask

  task automatic test_init_seq();
    logic [2:0] seq [5];
    seq = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2};
    bus.vc_empty = 4'hF; bus.umbral_lleno_in = 3'd3; bus.umbral_vacio_in = 3'd1;
    bus.init = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== seq[i]) begin errors++; $display("FAIL init_seq[%0d] got %0d want %0d", i, bus.state, seq[i]); end
      bus.init = (i < 3) ? 1'b1 : 1'b0;
      step();
    end
    checks++;
    if (bus.umbral_lleno !== 3'd3 || bus.umbral_vacio !== 3'd1) begin
      errors++; $display("FAIL init_thresholds got %0d/%0d want 3/1", bus.umbral_lleno, bus.umbral_vacio);
    end
    checks++;
    if (bus.idle_out !== 1'b1) begin errors++; $display("FAIL init_idle_out got %b want 1", bus.idle_out); end
  endtask

  task automatic test_bad_thresh();
    go_idle(3'd2, 3'd2);
    @(negedge clk);
    checks++;
    if (bus.state !== 3'd4 || bus.error_out !== 1'b1) begin
      errors++; $display("FAIL bad_thresh got state=%0d err=%b want 4/1", bus.state, bus.error_out);
    end
    step();
    bus.vc_empty = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state !== 3'd4 || bus.vc_rd !== 4'b0 || bus.main_wr !== 1'b0) begin
        errors++; $display("FAIL error_sticky[%0d] got state=%0d rd=%b wr=%b want 4/0000/0",
                           i, bus.state, bus.vc_rd, bus.main_wr);
      end
      step();
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.error_out !== 1'b0) begin
      errors++; $display("FAIL error_exit got state=%0d err=%b want 0/0", bus.state, bus.error_out);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    go_idle(3'd6, 3'd1);
    bus.vc_data  = {6'h04, 6'h03, 6'h02, 6'h01};
    bus.vc_empty = 4'h0;
    @(negedge clk);
    checks++;
    if (bus.state !== 3'd2 || bus.vc_rd !== 4'b0) begin
      errors++; $display("FAIL rr_idle got state=%0d rd=%b want 2/0000", bus.state, bus.vc_rd);
    end
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.vc_rd !== 4'(1 << (i % 4))) begin
        errors++; $display("FAIL rr_pop[%0d] got %b want %b", i, bus.vc_rd, 4'(1 << (i % 4)));
      end
      if (i > 0) begin
        checks++;
        if (bus.main_wr !== 1'b1 || bus.main_data !== 6'(((i - 1) % 4) + 1)) begin
          errors++; $display("FAIL rr_push[%0d] got wr=%b d=%h want 1/%h", i, bus.main_wr, bus.main_data, 6'(((i - 1) % 4) + 1));
        end
      end
      step();
    end
  endtask

  task automatic test_wrap();
    bus.vc_empty = 4'b1011;           // only VC2 pending
    @(negedge clk);
    checks++;
    if (bus.vc_rd !== 4'b0100) begin errors++; $display("FAIL wrap_first got %b want 0100", bus.vc_rd); end
    step();
    @(negedge clk);
    checks++;
    if (bus.grant !== 2'd2 || bus.vc_rd !== 4'b0100) begin
      errors++; $display("FAIL wrap_again got grant=%0d rd=%b want 2/0100", bus.grant, bus.vc_rd);
    end
    step();
    bus.vc_empty = 4'b1001;           // VC1 joins VC2
    @(negedge clk);
    checks++;
    if (bus.vc_rd !== 4'b0010) begin errors++; $display("FAIL wrap_vc1 got %b want 0010", bus.vc_rd); end
    step();
  endtask

  task automatic test_stall();
    bus.vc_empty = 4'h0;
    @(negedge clk);
    checks++;
    if (bus.vc_rd !== 4'b0100) begin errors++; $display("FAIL stall_pre got %b want 0100", bus.vc_rd); end
    step();
    bus.main_almost_full = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.vc_rd !== 4'b0 || bus.main_wr !== 1'b1 || bus.main_data !== 6'h03) begin
      errors++; $display("FAIL stall_inflight got rd=%b wr=%b d=%h want 0000/1/03", bus.vc_rd, bus.main_wr, bus.main_data);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.vc_rd !== 4'b0 || bus.main_wr !== 1'b0 || bus.state !== 3'd3) begin
      errors++; $display("FAIL stall_hold got rd=%b wr=%b st=%0d want 0000/0/3", bus.vc_rd, bus.main_wr, bus.state);
    end
    step();
    bus.main_almost_full = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.vc_rd !== 4'b1000) begin errors++; $display("FAIL stall_resume got %b want 1000", bus.vc_rd); end
    step();
  endtask

  task automatic test_overflow();
    bus.main_full = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.main_wr !== 1'b1) begin errors++; $display("FAIL ovf_pre got wr=%b want 1", bus.main_wr); end
    step();
    bus.main_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.error_out !== 1'b1 || bus.state !== 3'd4 || bus.vc_rd !== 4'b0 || bus.main_wr !== 1'b0) begin
        errors++; $display("FAIL ovf_error[%0d] got err=%b st=%0d rd=%b wr=%b want 1/4/0000/0",
                           i, bus.error_out, bus.state, bus.vc_rd, bus.main_wr);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    go_idle(3'd6, 3'd1);
    bus.vc_empty = 4'h0;
    step();
    step();
    checks++;
    if (bus.main_wr !== 1'b1) begin errors++; $display("FAIL mid_pre got wr=%b want 1", bus.main_wr); end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.main_wr !== 1'b0 || bus.state !== 3'd0 || bus.vc_rd !== 4'b0) begin
      errors++; $display("FAIL mid_reset got wr=%b st=%0d rd=%b want 0/0/0000", bus.main_wr, bus.state, bus.vc_rd);
    end
    step();
    reset = 1'b0;
    bus.init = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.main_wr !== 1'b0) begin errors++; $display("FAIL mid_after[%0d] got wr=%b want 0", i, bus.main_wr); end
      step();
    end
    bus.init = 1'b0;
  endtask

  task automatic test_random();
    int w;
    logic [3:0] exp_rd;
    for (int seg = 0; seg < 8; seg++) begin
      bus.init = 1'b1;
      bus.umbral_lleno_in = 3'($urandom_range(3, 7));
      bus.umbral_vacio_in = (seg == 5) ? bus.umbral_lleno_in : 3'($urandom_range(0, 2));
      bus.main_full = 1'b0; bus.main_almost_full = 1'b0;
      pulse_reset();
      for (int cyc = 0; cyc < 70; cyc++) begin
        bus.init             = (cyc < 2) ? 1'b1 : ($urandom_range(0, 49) == 0);
        bus.main_full        = ($urandom_range(0, 39) == 0);
        bus.main_almost_full = ($urandom_range(0, 3) == 0);
        bus.vc_empty         = 4'($urandom);
        bus.vc_data          = 24'($urandom);
        @(negedge clk);
        w = m_winner();
        exp_rd = 4'b0000;
        if (w >= 0) exp_rd[w] = 1'b1;
        checks++;
        if (bus.vc_rd !== exp_rd) begin
          errors++; $display("FAIL rnd_vc_rd s%0d c%0d got %b want %b", seg, cyc, bus.vc_rd, exp_rd);
        end
        checks++;
        if (bus.state !== 3'(m_state) || bus.grant !== 2'(m_grant)) begin
          errors++; $display("FAIL rnd_state s%0d c%0d got st=%0d g=%0d want %0d/%0d",
                             seg, cyc, bus.state, bus.grant, m_state, m_grant);
        end
        checks++;
        if (bus.main_wr !== 1'(m_wr) || bus.main_data !== 6'(m_data)) begin
          errors++; $display("FAIL rnd_push s%0d c%0d got wr=%b d=%h want %0d/%h",
                             seg, cyc, bus.main_wr, bus.main_data, m_wr, m_data);
        end
        checks++;
        if (bus.umbral_lleno !== 3'(m_ul) || bus.umbral_vacio !== 3'(m_uv) ||
            {bus.idle_out, bus.active_out, bus.error_out} !== {m_state == 2, m_state == 3, m_state == 4}) begin
          errors++; $display("FAIL rnd_status s%0d c%0d got ul=%0d uv=%0d f=%b want %0d/%0d/%b", seg, cyc,
                             bus.umbral_lleno, bus.umbral_vacio, {bus.idle_out, bus.active_out, bus.error_out},
                             m_ul, m_uv, {m_state == 2, m_state == 3, m_state == 4});
        end
        @(posedge clk);
        m_step();
        #1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    #1;
    test_reset();
    test_init_seq();
    test_bad_thresh();
    test_round_robin();
    test_wrap();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flow_arbiter_fsm.md
Name: flow_arbiter_fsm

Overview:
- Flow-control controller sitting upstream of the 6-bit Main FIFO.
- Arbitrates round-robin among four virtual-channel FIFOs (VC0–VC3), pops one word per grant, and pushes it into the Main FIFO.
- Stalls on the Main FIFO almost-full indication.
- Owns the RESET/INIT/IDLE/ACTIVE/ERROR sequencing and distributes the empty/full thresholds (umbrales) to the FIFOs.

Parameters:
- DATA_W, 6, data word width.
- NUM_VC, 4, number of virtual channels (logic written for exactly 4; 2-bit grant).
- UMBRAL_W, 3, threshold width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- init  in  1  request to (re)load thresholds.
- umbral_lleno_in  in  3  almost-full threshold to load.
- umbral_vacio_in  in  3  almost-empty threshold to load.
- vc_empty  in  4  empty flag per VC FIFO, bit i = VCi.
- vc_data  in  24  show-ahead head word per VC, VCi at [6i+5:6i].
- vc_rd  out  4  one-hot pop strobe to VC FIFOs (combinational).
- main_full  in  1  Main FIFO full.
- main_almost_full  in  1  Main FIFO almost full.
- main_wr  out  1  push strobe to Main FIFO (registered).
- main_data  out  6  word pushed to Main FIFO (registered).
- umbral_lleno  out  3  distributed almost-full threshold (registered).
- umbral_vacio  out  3  distributed almost-empty threshold (registered).
- grant  out  2  index of the most recently granted VC.
- state  out  3  current FSM state encoding.
- idle_out  out  1  high in IDLE.
- active_out  out  1  high in ACTIVE.
- error_out  out  1  sticky error flag.

Behaviour:
- State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- Reset asserted (async): state=RESET; vc_rd=0; main_wr=0; main_data=0; umbral_lleno=0; umbral_vacio=0; grant=3 (so VC0 wins first); idle_out=0; active_out=0; error_out=0.
- Reset asserted mid-transfer discards any in-flight word; no main_wr appears after reset.
- RESET: first clock after reset deasserts → INIT.
- INIT: every cycle umbral_lleno<=umbral_lleno_in and umbral_vacio<=umbral_vacio_in.
  - While init=1, stay in INIT.
  - When init=0: if umbral_vacio_in >= umbral_lleno_in → ERROR, else → IDLE.
  - vc_rd is held at 0 in INIT.
- IDLE: idle_out=1, vc_rd=0.
  - init=1 → INIT (priority over traffic).
  - Else if any vc_empty bit is 0 → ACTIVE.
- ACTIVE: active_out=1.
  - init=1 → INIT; no grant is issued that cycle.
  - Grant condition: main_almost_full=0 and at least one vc_empty bit is 0.
  - Winner = first non-empty VC searched in order grant+1, grant+2, grant+3, grant (mod 4).
  - On a grant: vc_rd[winner]=1 combinationally the same cycle; grant<=winner; main_data<=vc_data slice of winner; main_wr<=1 on the next cycle.
  - Otherwise vc_rd=0 and main_wr<=0.
  - At most one vc_rd bit is high in any cycle. Never pop an empty VC.
  - Throughput: one word per cycle while unstalled. Latency: pop to main_wr = 1 cycle.
  - All VCs empty and no grant this cycle → IDLE next cycle; a pending main_wr still completes.
  - main_almost_full=1 gives the slack needed for the single in-flight word. Stall takes effect the same cycle main_almost_full rises.
- ERROR:
  - Entered from any non-RESET state when main_wr=1 and main_full=1 in the same cycle (overflow).
  - Also entered from INIT on invalid thresholds.
  - In ERROR: error_out=1, vc_rd=0, main_wr=0, thresholds held.
  - ERROR is sticky; only reset exits it.
- Status outputs: idle_out, active_out and error_out are decoded from registered state. grant holds its value when there is no grant.

Test Plan:
- Reset, then init=1 for 2 cycles with lleno=3, vacio=1, then init=0 → state sequence 0,1,1,1,2; umbral_lleno=3, umbral_vacio=1; all outputs 0 during reset.
- In INIT with lleno=2, vacio=2, drop init → state=4, error_out=1; stays 4 until reset pulse returns state=0.
- All four VCs non-empty (heads 0x01, 0x02, 0x03, 0x04), main_almost_full=0 → vc_rd sequence 0001, 0010, 0100, 1000, 0001; main_data 0x01, 0x02, 0x03, 0x04 one cycle behind each pop.
- Only VC2 non-empty, grant=2 → VC2 granted again (wrap-around); VC1 becomes non-empty next cycle → VC1 granted after VC2 (order 3, 0, 1).
- main_almost_full rises mid-stream → vc_rd=0 that same cycle; the one in-flight main_wr still completes; resumes with the next VC in rotation when the flag falls.
- Force main_full=1 while main_wr=1 → error_out=1 next cycle; no further vc_rd. Assert reset mid-ACTIVE → main_wr=0 immediately, state=0.
